// File: rtl/use_collector_pkg.sv
// Shared constants, FSM state type and beat arithmetic for the USE stream collector.
package use_collector_pkg;

  localparam int DEF_LEN_WIDTH     = 6;
  localparam int DEF_MAX_USE_BYTES = 38;
  localparam int DEF_OUT_BUS_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } coll_state_e;

  function automatic int beats_for_len(input int len, input int bus_bytes = DEF_OUT_BUS_BYTES);
    return (len + bus_bytes - 1) / bus_bytes;
  endfunction

endpackage

// File: rtl/use_beat_serializer.sv
// Turns one latched record into a sequence of AXI-Stream beats; outputs are registered
// so tdata/tkeep/tlast stay put while tvalid waits for tready.
module use_beat_serializer
  import use_collector_pkg::*;
#(
  parameter int MAX_BYTES = DEF_MAX_USE_BYTES,
  parameter int LEN_W     = DEF_LEN_WIDTH,
  parameter int BUS_BYTES = DEF_OUT_BUS_BYTES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [MAX_BYTES*8-1:0] rec,
  input  logic [LEN_W-1:0]       len,
  output logic [BUS_BYTES*8-1:0] tdata,
  output logic [BUS_BYTES-1:0]   tkeep,
  output logic                   tlast,
  output logic                   tvalid,
  input  logic                   tready,
  output logic                   done
);

  // Handshake: a beat transfers on a clock edge where tvalid and tready are both high;
  // once tvalid rises the beat fields hold until that edge, and tvalid stays high
  // until the tlast beat transfers.

  logic [MAX_BYTES*8-1:0] rec_q;
  logic [MAX_BYTES*8-1:0] src_rec;
  logic [MAX_BYTES*8-1:0] shifted;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       src_len;
  logic [LEN_W-1:0]       idx_q;
  logic [LEN_W-1:0]       src_idx;
  logic [BUS_BYTES*8-1:0] nxt_data;
  logic [BUS_BYTES-1:0]   nxt_keep;
  logic                   nxt_last;

  // Next beat comes either from the record being loaded (beat 0) or the held one.
  always_comb begin
    src_rec  = load ? rec : rec_q;
    src_len  = load ? len : len_q;
    src_idx  = load ? '0 : idx_q + 1'b1;
    shifted  = src_rec >> (int'(src_idx) * BUS_BYTES * 8);
    nxt_data = '0;
    nxt_keep = '0;
    for (int j = 0; j < BUS_BYTES; j++) begin
      if (int'(src_idx) * BUS_BYTES + j < int'(src_len)) begin
        nxt_keep[j]        = 1'b1;
        nxt_data[j*8 +: 8] = shifted[j*8 +: 8];
      end
    end
    nxt_last = (int'(src_idx) + 1 >= beats_for_len(int'(src_len), BUS_BYTES));
  end

  assign done = tvalid & tready & tlast;

  always_ff @(posedge clk) begin
    if (reset) begin
      rec_q  <= '0;
      len_q  <= '0;
      idx_q  <= '0;
      tdata  <= '0;
      tkeep  <= '0;
      tlast  <= 1'b0;
      tvalid <= 1'b0;
    end else if (load) begin
      rec_q  <= rec;
      len_q  <= len;
      idx_q  <= '0;
      tdata  <= nxt_data;
      tkeep  <= nxt_keep;
      tlast  <= nxt_last;
      tvalid <= 1'b1;
    end else if (tvalid && tready) begin
      if (tlast) begin
        tdata  <= '0;
        tkeep  <= '0;
        tlast  <= 1'b0;
        tvalid <= 1'b0;
      end else begin
        idx_q <= src_idx;
        tdata <= nxt_data;
        tkeep <= nxt_keep;
        tlast <= nxt_last;
      end
    end
  end

endmodule

// File: rtl/use_stream_collector.sv
// Latches one-cycle USE records from the ring elements into per-element slots and drains
// them in strict token order onto an AXI-Stream master, one packet per record.
module use_stream_collector
  import use_collector_pkg::*;
#(
  parameter int NUM_ELEMENTS          = 6,
  parameter int MAX_USE_BYTES         = DEF_MAX_USE_BYTES,
  parameter int LEN_WIDTH             = DEF_LEN_WIDTH,
  parameter int OUT_BUS_BYTES         = DEF_OUT_BUS_BYTES,
  parameter int RESET_TOKEN_HOLDER_ID = 0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_ELEMENTS*MAX_USE_BYTES*8-1:0] use_stream_in,
  input  logic [NUM_ELEMENTS*LEN_WIDTH-1:0]      use_len_in,
  input  logic [NUM_ELEMENTS-1:0]                use_ready_in,
  output logic [OUT_BUS_BYTES*8-1:0]             m_axis_tdata,
  output logic [OUT_BUS_BYTES-1:0]               m_axis_tkeep,
  output logic                                   m_axis_tlast,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic [NUM_ELEMENTS-1:0]                slot_pending,
  output logic                                   overflow_err,
  output logic                                   len_err,
  output logic [31:0]                            records_sent
);

  localparam int REC_W = MAX_USE_BYTES * 8;
  localparam int PTR_W = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(RESET_TOKEN_HOLDER_ID);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_ELEMENTS - 1);

  coll_state_e          state;
  logic [PTR_W-1:0]     ptr;
  logic [REC_W-1:0]     slot_rec [NUM_ELEMENTS];
  logic [LEN_WIDTH-1:0] slot_len [NUM_ELEMENTS];
  logic [NUM_ELEMENTS-1:0] cap_full;
  logic [NUM_ELEMENTS-1:0] cap_len_ok;
  logic                 ser_load;
  logic                 ser_done;

  assign ser_load = (state == LOAD);

  // The slot being copied out in LOAD counts as free, so a same-cycle pulse is kept.
  always_comb begin
    cap_full   = '0;
    cap_len_ok = '0;
    for (int e = 0; e < NUM_ELEMENTS; e++) begin
      cap_full[e]   = slot_pending[e] && !(ser_load && (ptr == PTR_W'(e)));
      cap_len_ok[e] = (use_len_in[e*LEN_WIDTH +: LEN_WIDTH] != '0) &&
                      (int'(use_len_in[e*LEN_WIDTH +: LEN_WIDTH]) <= MAX_USE_BYTES);
    end
  end

  use_beat_serializer #(
    .MAX_BYTES (MAX_USE_BYTES),
    .LEN_W     (LEN_WIDTH),
    .BUS_BYTES (OUT_BUS_BYTES)
  ) u_serializer (
    .clk    (clk),
    .reset  (reset),
    .load   (ser_load),
    .rec    (slot_rec[ptr]),
    .len    (slot_len[ptr]),
    .tdata  (m_axis_tdata),
    .tkeep  (m_axis_tkeep),
    .tlast  (m_axis_tlast),
    .tvalid (m_axis_tvalid),
    .tready (m_axis_tready),
    .done   (ser_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= PTR_RESET;
      slot_pending <= '0;
      overflow_err <= 1'b0;
      len_err      <= 1'b0;
      records_sent <= '0;
      for (int e = 0; e < NUM_ELEMENTS; e++) begin
        slot_rec[e] <= '0;
        slot_len[e] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (slot_pending[ptr]) state <= LOAD;
        LOAD: begin
          slot_pending[ptr] <= 1'b0;
          state             <= SEND;
        end
        SEND: if (ser_done) begin
          records_sent <= records_sent + 32'd1;
          ptr          <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Captures come after the LOAD clear so a same-cycle pulse re-sets pending.
      for (int e = 0; e < NUM_ELEMENTS; e++) begin
        if (use_ready_in[e]) begin
          if (cap_full[e]) overflow_err <= 1'b1;
          if (!cap_len_ok[e]) len_err <= 1'b1;
          if (!cap_full[e] && cap_len_ok[e]) begin
            slot_pending[e] <= 1'b1;
            slot_rec[e]     <= use_stream_in[e*REC_W +: REC_W];
            slot_len[e]     <= use_len_in[e*LEN_WIDTH +: LEN_WIDTH];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_use_stream_collector.sv
// Bench for use_stream_collector: packet-level reference model with a per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_use_stream_collector;

  localparam int N     = 6;
  localparam int MAX   = 38;
  localparam int LW    = 6;
  localparam int B     = 8;
  localparam int REC_W = MAX * 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N*REC_W-1:0]   use_stream_in;
  logic [N*LW-1:0]      use_len_in;
  logic [N-1:0]         use_ready_in;
  logic [B*8-1:0]       m_axis_tdata;
  logic [B-1:0]         m_axis_tkeep;
  logic                 m_axis_tlast;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic [N-1:0]         slot_pending;
  logic                 overflow_err;
  logic                 len_err;
  logic [31:0]          records_sent;

  use_stream_collector #(
    .NUM_ELEMENTS(N), .MAX_USE_BYTES(MAX), .LEN_WIDTH(LW),
    .OUT_BUS_BYTES(B), .RESET_TOKEN_HOLDER_ID(0)
  ) dut (
    .clk(clk), .reset(reset),
    .use_stream_in(use_stream_in), .use_len_in(use_len_in), .use_ready_in(use_ready_in),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .slot_pending(slot_pending), .overflow_err(overflow_err), .len_err(len_err),
    .records_sent(records_sent)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- counters and check helper ----------------
  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Beats packed as {data, keep, last}.
  logic [B*8+B:0]   exp_q[$];
  logic [N-1:0]     m_pending;
  logic [REC_W-1:0] m_rec [N];
  int               m_len [N];
  int               m_ptr;
  bit               m_load;
  logic [31:0]      m_sent;
  bit               m_ovf;
  bit               m_lerr;

  task automatic build_packet(input logic [REC_W-1:0] rec, input int len);
    int nb;
    logic [B*8-1:0] d;
    logic [B-1:0]   k;
    nb = (len + B - 1) / B;
    for (int bt = 0; bt < nb; bt++) begin
      d = '0;
      k = '0;
      for (int j = 0; j < B; j++) begin
        if (bt * B + j < len) begin
          k[j]        = 1'b1;
          d[j*8 +: 8] = rec[(bt*B + j)*8 +: 8];
        end
      end
      exp_q.push_back({d, k, (bt == nb - 1)});
    end
  endtask

  always @(posedge clk) begin : model_step
    logic [N-1:0]   old_pending;
    int             old_ptr;
    bit             was_load;
    bit             full;
    int             l;
    logic [B*8+B:0] beat;
    if (reset) begin
      m_pending = '0;
      m_ptr     = 0;
      m_load    = 1'b0;
      m_sent    = '0;
      m_ovf     = 1'b0;
      m_lerr    = 1'b0;
      exp_q.delete();
    end else begin
      old_pending = m_pending;
      old_ptr     = m_ptr;
      was_load    = m_load;
      m_load      = 1'b0;
      if (was_load) begin
        build_packet(m_rec[old_ptr], m_len[old_ptr]);
        m_pending[old_ptr] = 1'b0;
      end else if (exp_q.size() > 0) begin
        if (m_axis_tready) begin
          beat = exp_q.pop_front();
          if (beat[0]) begin
            m_sent = m_sent + 1;
            m_ptr  = (m_ptr + 1) % N;
          end
        end
      end else if (old_pending[old_ptr]) begin
        m_load = 1'b1;
      end
      for (int e = 0; e < N; e++) begin
        if (use_ready_in[e]) begin
          l    = int'(use_len_in[e*LW +: LW]);
          full = old_pending[e] && !(was_load && e == old_ptr);
          if (full) m_ovf = 1'b1;
          if (l == 0 || l > MAX) m_lerr = 1'b1;
          if (!full && l >= 1 && l <= MAX) begin
            m_pending[e] = 1'b1;
            m_rec[e]     = use_stream_in[e*REC_W +: REC_W];
            m_len[e]     = l;
          end
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("tvalid", m_axis_tvalid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        chk("tdata", m_axis_tdata, exp_q[0][B*8+B:B+1]);
        chk("tkeep", m_axis_tkeep, exp_q[0][B:1]);
        chk("tlast", m_axis_tlast, exp_q[0][0]);
      end
      chk("slot_pending", slot_pending, m_pending);
      chk("overflow_err", overflow_err, m_ovf);
      chk("len_err", len_err, m_lerr);
      chk("records_sent", records_sent, m_sent);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    use_ready_in = '0;
  endtask

  task automatic pulse_set(input int e, input int len);
    for (int b = 0; b < MAX; b++) use_stream_in[(e*MAX + b)*8 +: 8] = 8'($urandom);
    use_len_in[e*LW +: LW] = LW'(len);
    use_ready_in[e]        = 1'b1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!m_axis_tvalid && n < 50) begin
      step();
      n++;
    end
    if (!m_axis_tvalid) chk("wait_valid_timeout", n, 0);
  endtask

  // Observes one packet at the handshakes; bp applies a 1,0,0,1 tready pattern.
  logic [7:0] got_keep [8];
  int         last_mask;

  task automatic collect(input bit bp, output int nb, output logic [7:0] lk);
    bit got_last;
    int cyc;
    nb        = 0;
    lk        = '0;
    got_last  = 1'b0;
    cyc       = 0;
    last_mask = 0;
    while (!got_last && cyc < 100) begin
      if (bp) m_axis_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (m_axis_tvalid && m_axis_tready) begin
        if (nb < 8) got_keep[nb] = m_axis_tkeep;
        if (m_axis_tlast) begin
          last_mask = last_mask | (1 << nb);
          got_last  = 1'b1;
        end
        lk = m_axis_tkeep;
        nb++;
      end
      step();
      cyc++;
    end
    m_axis_tready = 1'b1;
    if (!got_last) chk("collect_timeout", cyc, 0);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    m_axis_tready = 1'b1;
    while ((exp_q.size() > 0 || m_pending != '0 || m_load) && n < limit) begin
      if (exp_q.size() == 0 && !m_load && m_pending != '0 && !m_pending[m_ptr])
        pulse_set(m_ptr, $urandom_range(1, MAX));
      step();
      n++;
    end
    if (n >= limit) chk("drain_timeout", n, 0);
  endtask

  function automatic int rand_len();
    if ($urandom_range(0, 15) == 0)
      return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAX + 1, 63));
    return int'($urandom_range(1, MAX));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int         n;
    int         nb;
    logic [7:0] lk;
    reset         = 1'b1;
    use_stream_in = '0;
    use_len_in    = '0;
    use_ready_in  = '0;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_pending", slot_pending, 6'd0);
    chk("rst_records", records_sent, 32'd0);
    chk("rst_flags", {overflow_err, len_err}, 2'b00);
    reset  = 1'b0;
    chk_on = 1'b1;

    // Single record, element 0, len 27.
    m_axis_tready = 1'b1;
    pulse_set(0, 27);
    step();
    wait_valid(n);
    chk("t1_latency", n, 2);
    collect(1'b0, nb, lk);
    chk("t1_beats", nb, 4);
    chk("t1_keep0", got_keep[0], 8'hFF);
    chk("t1_keep1", got_keep[1], 8'hFF);
    chk("t1_keep2", got_keep[2], 8'hFF);
    chk("t1_keep3", got_keep[3], 8'h07);
    chk("t1_lastmask", last_mask, 4'b1000);
    chk("t1_records", records_sent, 32'd1);

    // Token now at 1: a record in slot 2 must wait.
    pulse_set(2, 5);
    step();
    repeat (4) step();
    chk("ptr1_pending", slot_pending, 6'b000100);
    chk("ptr1_idle", m_axis_tvalid, 1'b0);
    pulse_set(1, 12);
    step();
    drain(200);

    // Out-of-order completion after reset: element 1 before element 0.
    do_reset(2);
    pulse_set(1, 21);
    step();
    repeat (3) step();
    chk("t2_pending", slot_pending, 6'b000010);
    chk("t2_idle", m_axis_tvalid, 1'b0);
    pulse_set(0, 19);
    step();
    wait_valid(n);
    collect(1'b0, nb, lk);
    chk("t2_first_beats", nb, 3);
    chk("t2_first_keep", lk, 8'h07);
    wait_valid(n);
    collect(1'b0, nb, lk);
    chk("t2_second_beats", nb, 3);
    chk("t2_second_keep", lk, 8'h1F);

    // Ring wrap with 5 and 0 pulsing together.
    pulse_set(2, 8);  step();
    pulse_set(3, 38); step();
    pulse_set(4, 1);  step();
    pulse_set(5, 16);
    pulse_set(0, 9);
    step();
    drain(300);
    chk("t3_records", records_sent, 32'd7);
    chk("t3_pending", slot_pending, 6'd0);

    // Backpressure, element 1, len 33.
    pulse_set(1, 33);
    step();
    wait_valid(n);
    collect(1'b1, nb, lk);
    chk("t4_beats", nb, 5);
    chk("t4_last_keep", lk, 8'h01);

    // Overflow on slot 2 while stalled, then a capture during its LOAD cycle.
    m_axis_tready = 1'b0;
    pulse_set(2, 10); step();
    pulse_set(2, 20); step();
    pulse_set(2, 7);
    pulse_set(3, 14);
    step();
    repeat (6) step();
    chk("t5_overflow", overflow_err, 1'b1);
    chk("t5_pending", slot_pending, 6'b001100);
    chk("t5_stall_valid", m_axis_tvalid, 1'b1);
    chk("t5_stall_keep", m_axis_tkeep, 8'hFF);
    m_axis_tready = 1'b1;
    collect(1'b0, nb, lk);
    chk("t5_beats", nb, 2);
    chk("t5_last_keep", lk, 8'h03);
    drain(600);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      for (int e = 0; e < N; e++)
        if ($urandom_range(0, 11) == 0) pulse_set(e, rand_len());
      m_axis_tready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain(2000);

    // Length error, then reset in the middle of a packet.
    do_reset(2);
    pulse_set(0, 0);
    step();
    repeat (4) step();
    chk("t6_len_err", len_err, 1'b1);
    chk("t6_no_emit", m_axis_tvalid, 1'b0);
    chk("t6_pending", slot_pending, 6'd0);
    pulse_set(0, 30);
    step();
    wait_valid(n);
    step();
    reset = 1'b1;
    step();
    chk("t6_rst_valid", m_axis_tvalid, 1'b0);
    chk("t6_rst_flags", {overflow_err, len_err}, 2'b00);
    chk("t6_rst_pending", slot_pending, 6'd0);
    chk("t6_rst_records", records_sent, 32'd0);
    reset = 1'b0;
    pulse_set(3, 5);
    step();
    repeat (3) step();
    chk("t6_ptr0_pending", slot_pending, 6'b001000);
    chk("t6_ptr0_idle", m_axis_tvalid, 1'b0);
    drain(300);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
